dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK clocks all state, and RST resets it at a CLK rising edge.
REQ-002 The block SHALL have these ports: CLK in 1 clock; RST in 1 sync active-high reset.
REQ-003 It SHALL have these CPU-side ports: CPU_REQ in 1 memory op active; CPU_WE in 1 store; CPU_ADDR in 12 word address; CPU_DIN in 32 store data; CPU_DOUT out 32 load data; CPU_STALL out 1 drives processor HLT.
REQ-004 It SHALL have these host-side ports: HOST_REQ in 1; HOST_WE in 1; HOST_ADDR in 12; HOST_DIN in 32; HOST_GNT out 1 access accepted; HOST_DOUT out 32; HOST_VLD out 1 read data valid.
REQ-005 It SHALL have these BRAM port-B ports: MEM_EN out 1; MEM_WE out 1; MEM_ADDR out 12; MEM_DIN out 32; MEM_DOUT in 32, with 1-cycle read latency.
REQ-006 Under DMEM_ARB_STATS_EN it SHALL additionally have: CONFLICT_CNT out 16 saturating conflict count.

Function
REQ-007 The block SHALL issue at most one BRAM access per cycle; it SHALL drive MEM_EN=1 only in a cycle where an access is granted.
REQ-008 A CPU request is eligible when CPU_REQ=1 and state=IDLE; a host request is eligible when HOST_REQ=1.
REQ-009 On a conflict (both eligible) the grant SHALL go to the requester that was not granted last, tracked in register LAST (0=CPU, 1=HOST); LAST SHALL update on every grant.
REQ-010 With exactly one requester eligible, that requester SHALL be granted the same cycle.
REQ-011 The MEM_* outputs SHALL be combinationally muxed from the granted requester's WE/ADDR/DIN.
REQ-012 HOST_GNT SHALL be a 1-cycle pulse in the grant cycle; the host holds its request fields stable until HOST_GNT=1.
REQ-013 For a granted host read, HOST_VLD SHALL be 1 for exactly the next cycle, with HOST_DOUT=MEM_DOUT; HOST_DOUT SHALL hold its last value otherwise.
REQ-014 The FSM SHALL have states IDLE and CPU_RDATA; IDLE->CPU_RDATA on a CPU read grant; CPU_RDATA->IDLE unconditionally after one cycle.
REQ-015 In CPU_RDATA, CPU_DOUT SHALL equal MEM_DOUT and the CPU request SHALL be treated as consumed (not re-issued); the host MAY be granted in that cycle.
REQ-016 CPU_STALL SHALL be combinational, asserted when CPU_REQ=1 AND NOT (CPU write granted this cycle OR state=CPU_RDATA); CPU_STALL SHALL be 0 when CPU_REQ=0.
REQ-017 A CPU write SHALL complete in 1 cycle if granted (no stall); a CPU read SHALL take 2 cycles minimum (stall=1 in the grant cycle, stall=0 in CPU_RDATA).
REQ-018 A host write and a host read SHALL each consume exactly one grant cycle.
REQ-019 Requests dropped before grant SHALL have no effect; no request is queued.

Reset
REQ-020 RST SHALL set state=IDLE, LAST=1 (so the CPU wins the first conflict), HOST_VLD=0, HOST_DOUT=0, and CONFLICT_CNT=0.
REQ-021 During RST=1, MEM_EN, MEM_WE, HOST_GNT and CPU_STALL SHALL be 0.
REQ-022 An RST asserted while in CPU_RDATA or with host read data pending SHALL discard the pending data: the next cycle HOST_VLD=0 and state=IDLE.

Configuration
REQ-023 With DMEM_ARB_STATS_EN defined, CONFLICT_CNT SHALL increment by 1 in each cycle where both requesters are eligible, saturating at 16'hFFFF; without the macro, the port and counter SHALL be absent and the other behaviour SHALL be unchanged.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (IDLE, CPU_RDATA), the width constants ADDR_W=12 and DATA_W=32, and the LAST encodings.
REQ-025 The round-robin grant decision SHALL be a sub-module rr_arb2 (inputs: two requests and LAST; outputs: one-hot grant).

Verification
REQ-026 Scenario 1: CPU write ADDR=0x010, DIN=0xDEADBEEF, host idle -> MEM_EN=MEM_WE=1, MEM_ADDR=0x010 in the same cycle, CPU_STALL=0.
REQ-027 Scenario 2: CPU read of 0x010 -> cycle 0 CPU_STALL=1; cycle 1 CPU_STALL=0 and CPU_DOUT=0xDEADBEEF.
REQ-028 Scenario 3: after reset, simultaneous CPU read 0x001 and host write 0x002 -> CPU is granted first; the host gets HOST_GNT in the next cycle (CPU_RDATA); CONFLICT_CNT=1 when DMEM_ARB_STATS_EN is defined.
REQ-029 Scenario 4: CPU and host both hold write requests for 4 cycles -> grants alternate CPU, HOST, CPU, HOST, and CPU_STALL=1 only in the host-granted cycles.
REQ-030 Scenario 5: host read of 0x3FF containing 0x12345678 -> HOST_GNT in cycle 0; HOST_VLD=1 with HOST_DOUT=0x12345678 in cycle 1.
REQ-031 Scenario 6: RST asserted in the CPU_RDATA cycle -> the next cycle state=IDLE, HOST_VLD=0, and a CPU_REQ still high is re-arbitrated as a new request.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared widths, FSM encoding and round-robin encodings for dmem_arbiter
package dmem_arbiter_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {
    IDLE      = 1'b0,
    CPU_RDATA = 1'b1
  } state_t;

  localparam logic LAST_CPU  = 1'b0;
  localparam logic LAST_HOST = 1'b1;

  // Grant vector bit positions.
  localparam int GNT_CPU  = 0;
  localparam int GNT_HOST = 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin grant: on conflict the side not granted last wins
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       req_cpu,
  input  logic       req_host,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req_cpu && req_host) begin
      if (last == LAST_HOST) gnt[GNT_CPU] = 1'b1;
      else                   gnt[GNT_HOST] = 1'b1;
    end else if (req_cpu) begin
      gnt[GNT_CPU] = 1'b1;
    end else if (req_host) begin
      gnt[GNT_HOST] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one BRAM port between CPU and host with round-robin on conflict
// Optional saturating conflict counter port CONFLICT_CNT under DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DIN,
  output logic [DATA_W-1:0] CPU_DOUT,
  output logic              CPU_STALL,
  input  logic              HOST_REQ,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_DIN,
  output logic              HOST_GNT,
  output logic [DATA_W-1:0] HOST_DOUT,
  output logic              HOST_VLD,
`ifdef DMEM_ARB_STATS_EN
  output logic [CNT_W-1:0]  CONFLICT_CNT,
`endif
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DIN,
  input  logic [DATA_W-1:0] MEM_DOUT
);

  state_t            state;
  state_t            next_state;
  logic              last;
  logic              host_pend;
  logic [DATA_W-1:0] host_dout_q;
  logic              cpu_elig;
  logic              host_elig;
  logic [1:0]        gnt;
  logic              gnt_cpu;
  logic              gnt_host;

  // Eligibility is masked by reset so no access or grant leaks out while RST=1.
  assign cpu_elig  = CPU_REQ && (state == IDLE) && !RST;
  assign host_elig = HOST_REQ && !RST;

  rr_arb2 u_rr_arb2 (
    .req_cpu  (cpu_elig),
    .req_host (host_elig),
    .last     (last),
    .gnt      (gnt)
  );

  assign gnt_cpu  = gnt[GNT_CPU];
  assign gnt_host = gnt[GNT_HOST];

  always_comb begin
    MEM_EN   = gnt_cpu | gnt_host;
    MEM_WE   = 1'b0;
    MEM_ADDR = CPU_ADDR;
    MEM_DIN  = CPU_DIN;
    if (gnt_host) begin
      MEM_WE   = HOST_WE;
      MEM_ADDR = HOST_ADDR;
      MEM_DIN  = HOST_DIN;
    end else if (gnt_cpu) begin
      MEM_WE = CPU_WE;
    end
  end

  assign HOST_GNT = gnt_host;

  // A CPU read stalls in its grant cycle and is released in CPU_RDATA.
  assign CPU_STALL = CPU_REQ && !RST &&
                     !((gnt_cpu && CPU_WE) || (state == CPU_RDATA));
  assign CPU_DOUT  = MEM_DOUT;

  assign HOST_VLD  = host_pend;
  assign HOST_DOUT = host_pend ? MEM_DOUT : host_dout_q;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (gnt_cpu && !CPU_WE) next_state = CPU_RDATA;
      CPU_RDATA: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last        <= LAST_HOST;
      host_pend   <= 1'b0;
      host_dout_q <= '0;
    end else begin
      if (gnt_cpu)       last <= LAST_CPU;
      else if (gnt_host) last <= LAST_HOST;
      host_pend <= gnt_host && !HOST_WE;
      if (host_pend) host_dout_q <= MEM_DOUT;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] conflict_cnt;

  always_ff @(posedge CLK) begin
    if (RST)                         conflict_cnt <= '0;
    else if (cpu_elig && host_elig)  conflict_cnt <= sat_inc(conflict_cnt);
  end

  assign CONFLICT_CNT = conflict_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a 1-cycle BRAM model
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic              CLK = 1'b0;
  logic              RST;
  logic              CPU_REQ, CPU_WE;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] CPU_DIN, CPU_DOUT;
  logic              CPU_STALL;
  logic              HOST_REQ, HOST_WE;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [DATA_W-1:0] HOST_DIN, HOST_DOUT;
  logic              HOST_GNT, HOST_VLD;
  logic              MEM_EN, MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DIN, MEM_DOUT;
`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0]  CONFLICT_CNT;
`endif

  logic [DATA_W-1:0] mem [0:4095];

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .CPU_REQ   (CPU_REQ),
    .CPU_WE    (CPU_WE),
    .CPU_ADDR  (CPU_ADDR),
    .CPU_DIN   (CPU_DIN),
    .CPU_DOUT  (CPU_DOUT),
    .CPU_STALL (CPU_STALL),
    .HOST_REQ  (HOST_REQ),
    .HOST_WE   (HOST_WE),
    .HOST_ADDR (HOST_ADDR),
    .HOST_DIN  (HOST_DIN),
    .HOST_GNT  (HOST_GNT),
    .HOST_DOUT (HOST_DOUT),
    .HOST_VLD  (HOST_VLD),
`ifdef DMEM_ARB_STATS_EN
    .CONFLICT_CNT (CONFLICT_CNT),
`endif
    .MEM_EN    (MEM_EN),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DIN   (MEM_DIN),
    .MEM_DOUT  (MEM_DOUT)
  );

  // Read-first BRAM port with 1-cycle read latency.
  always @(posedge CLK) begin
    if (MEM_EN) begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_DIN;
      MEM_DOUT <= mem[MEM_ADDR];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    RST = 1'b0;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DIN = '0;
    HOST_REQ = 1'b0; HOST_WE = 1'b0; HOST_ADDR = '0; HOST_DIN = '0;
  endtask

  task automatic cpu_op(input logic we, input logic [11:0] a, input logic [31:0] d);
    CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = a; CPU_DIN = d;
  endtask

  task automatic host_op(input logic we, input logic [11:0] a, input logic [31:0] d);
    HOST_REQ = 1'b1; HOST_WE = we; HOST_ADDR = a; HOST_DIN = d;
  endtask

  task automatic do_reset();
    @(negedge CLK); idle_in(); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
  endtask

  initial begin
    idle_in();

    // Reset with both sides requesting: nothing may be granted.
    @(negedge CLK); RST = 1'b1; cpu_op(1'b1, 12'h005, 32'h1); host_op(1'b1, 12'h006, 32'h2); #1;
    chk("rst_mem_en", {31'b0, MEM_EN}, 32'd0);
    chk("rst_mem_we", {31'b0, MEM_WE}, 32'd0);
    chk("rst_host_gnt", {31'b0, HOST_GNT}, 32'd0);
    chk("rst_cpu_stall", {31'b0, CPU_STALL}, 32'd0);
    @(negedge CLK); idle_in(); #1;
    chk("rst_host_vld", {31'b0, HOST_VLD}, 32'd0);
    chk("rst_host_dout", HOST_DOUT, 32'd0);
    chk("idle_mem_en", {31'b0, MEM_EN}, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_conflict_cnt", {16'b0, CONFLICT_CNT}, 32'd0);
`endif

    // Preload memory through the host side.
    @(negedge CLK); host_op(1'b1, 12'h3FF, 32'h12345678); #1;
    chk("pre0_host_gnt", {31'b0, HOST_GNT}, 32'd1);
    @(negedge CLK); host_op(1'b1, 12'h001, 32'hA5A50001); #1;
    chk("pre1_host_gnt", {31'b0, HOST_GNT}, 32'd1);
    do_reset();

    // Scenario 1: CPU write, host idle.
    @(negedge CLK); cpu_op(1'b1, 12'h010, 32'hDEADBEEF); #1;
    chk("s1_mem_en", {31'b0, MEM_EN}, 32'd1);
    chk("s1_mem_we", {31'b0, MEM_WE}, 32'd1);
    chk("s1_mem_addr", {20'b0, MEM_ADDR}, 32'h010);
    chk("s1_mem_din", MEM_DIN, 32'hDEADBEEF);
    chk("s1_cpu_stall", {31'b0, CPU_STALL}, 32'd0);

    // Scenario 2: CPU read back, two cycles.
    @(negedge CLK); cpu_op(1'b0, 12'h010, 32'h0); #1;
    chk("s2c0_cpu_stall", {31'b0, CPU_STALL}, 32'd1);
    chk("s2c0_mem_en", {31'b0, MEM_EN}, 32'd1);
    chk("s2c0_mem_we", {31'b0, MEM_WE}, 32'd0);
    @(negedge CLK); #1;
    chk("s2c1_cpu_stall", {31'b0, CPU_STALL}, 32'd0);
    chk("s2c1_cpu_dout", CPU_DOUT, 32'hDEADBEEF);
    chk("s2c1_mem_en", {31'b0, MEM_EN}, 32'd0);
    @(negedge CLK); idle_in(); #1;
    chk("s2c2_cpu_stall", {31'b0, CPU_STALL}, 32'd0);

    // Scenario 3: conflict right after reset, CPU read wins.
    do_reset();
    @(negedge CLK); cpu_op(1'b0, 12'h001, 32'h0); host_op(1'b1, 12'h002, 32'h0BADF00D); #1;
    chk("s3c0_host_gnt", {31'b0, HOST_GNT}, 32'd0);
    chk("s3c0_mem_addr", {20'b0, MEM_ADDR}, 32'h001);
    chk("s3c0_cpu_stall", {31'b0, CPU_STALL}, 32'd1);
    @(negedge CLK); #1;
    chk("s3c1_host_gnt", {31'b0, HOST_GNT}, 32'd1);
    chk("s3c1_mem_addr", {20'b0, MEM_ADDR}, 32'h002);
    chk("s3c1_mem_we", {31'b0, MEM_WE}, 32'd1);
    chk("s3c1_mem_din", MEM_DIN, 32'h0BADF00D);
    chk("s3c1_cpu_stall", {31'b0, CPU_STALL}, 32'd0);
    chk("s3c1_cpu_dout", CPU_DOUT, 32'hA5A50001);
`ifdef DMEM_ARB_STATS_EN
    chk("s3_conflict_cnt", {16'b0, CONFLICT_CNT}, 32'd1);
`endif
    @(negedge CLK); idle_in();

    // Scenario 4: four cycles of competing writes alternate, CPU first (host won last).
    @(negedge CLK); cpu_op(1'b1, 12'h020, 32'h11111111); host_op(1'b1, 12'h021, 32'h22222222); #1;
    chk("s4a_host_gnt", {31'b0, HOST_GNT}, 32'd0);
    chk("s4a_cpu_stall", {31'b0, CPU_STALL}, 32'd0);
    chk("s4a_mem_addr", {20'b0, MEM_ADDR}, 32'h020);
    @(negedge CLK); cpu_op(1'b1, 12'h022, 32'h33333333); #1;
    chk("s4b_host_gnt", {31'b0, HOST_GNT}, 32'd1);
    chk("s4b_cpu_stall", {31'b0, CPU_STALL}, 32'd1);
    chk("s4b_mem_addr", {20'b0, MEM_ADDR}, 32'h021);
    @(negedge CLK); host_op(1'b1, 12'h023, 32'h44444444); #1;
    chk("s4c_host_gnt", {31'b0, HOST_GNT}, 32'd0);
    chk("s4c_cpu_stall", {31'b0, CPU_STALL}, 32'd0);
    chk("s4c_mem_addr", {20'b0, MEM_ADDR}, 32'h022);
    @(negedge CLK); cpu_op(1'b1, 12'h024, 32'h55555555); #1;
    chk("s4d_host_gnt", {31'b0, HOST_GNT}, 32'd1);
    chk("s4d_cpu_stall", {31'b0, CPU_STALL}, 32'd1);
    chk("s4d_mem_addr", {20'b0, MEM_ADDR}, 32'h023);
    @(negedge CLK); idle_in(); #1;
`ifdef DMEM_ARB_STATS_EN
    chk("s4_conflict_cnt", {16'b0, CONFLICT_CNT}, 32'd5);
`endif

    // Scenario 5: host reads, data valid exactly one cycle later, then held.
    @(negedge CLK); host_op(1'b0, 12'h3FF, 32'h0); #1;
    chk("s5c0_host_gnt", {31'b0, HOST_GNT}, 32'd1);
    chk("s5c0_mem_addr", {20'b0, MEM_ADDR}, 32'h3FF);
    chk("s5c0_host_vld", {31'b0, HOST_VLD}, 32'd0);
    @(negedge CLK); idle_in(); #1;
    chk("s5c1_host_vld", {31'b0, HOST_VLD}, 32'd1);
    chk("s5c1_host_dout", HOST_DOUT, 32'h12345678);
    @(negedge CLK); host_op(1'b0, 12'h021, 32'h0); #1;
    chk("s5c2_host_vld", {31'b0, HOST_VLD}, 32'd0);
    chk("s5c2_host_dout_hold", HOST_DOUT, 32'h12345678);
    @(negedge CLK); idle_in(); #1;
    chk("s5c3_host_vld", {31'b0, HOST_VLD}, 32'd1);
    chk("s5c3_host_dout", HOST_DOUT, 32'h22222222);

    // Scenario 6: reset in CPU_RDATA, held CPU request is re-arbitrated.
    @(negedge CLK); cpu_op(1'b0, 12'h022, 32'h0); #1;
    chk("s6c0_cpu_stall", {31'b0, CPU_STALL}, 32'd1);
    @(negedge CLK); RST = 1'b1; #1;
    chk("s6c1_cpu_stall", {31'b0, CPU_STALL}, 32'd0);
    chk("s6c1_mem_en", {31'b0, MEM_EN}, 32'd0);
    @(negedge CLK); RST = 1'b0; #1;
    chk("s6c2_mem_en", {31'b0, MEM_EN}, 32'd1);
    chk("s6c2_cpu_stall", {31'b0, CPU_STALL}, 32'd1);
    chk("s6c2_host_vld", {31'b0, HOST_VLD}, 32'd0);
    @(negedge CLK); #1;
    chk("s6c3_cpu_stall", {31'b0, CPU_STALL}, 32'd0);
    chk("s6c3_cpu_dout", CPU_DOUT, 32'h33333333);

    // Reset with host read data pending discards it.
    @(negedge CLK); idle_in(); host_op(1'b0, 12'h3FF, 32'h0); #1;
    chk("s7c0_host_gnt", {31'b0, HOST_GNT}, 32'd1);
    @(negedge CLK); idle_in(); RST = 1'b1; #1;
    chk("s7c1_host_vld", {31'b0, HOST_VLD}, 32'd1);
    @(negedge CLK); RST = 1'b0; #1;
    chk("s7c2_host_vld", {31'b0, HOST_VLD}, 32'd0);
    chk("s7c2_host_dout", HOST_DOUT, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
